riego_status_encoder: RTL and testbench
=======================================

Name: riego_status_encoder

Overview:
- Upstream stage of the LCD text block in the smart-watering design.
- Turns raw humidity and light sensor samples into the 3-bit message code the LCD block displays:
  - 0 = HUMEDAD OK / LUZ OK
  - 1 = LUZ LOW
  - 2 = HUMEDAD LOW
  - 3 = both LOW
  - 4 = WARNING!!!!
- Applies threshold hysteresis, sample debouncing and a dry-time watchdog, and drives the pump enable.

Parameters:
- DATA_W, 10, width of sensor samples (unsigned)
- HUM_LOW_TH, 300, humidity below this is low
- HUM_HYST, 20, humidity must reach HUM_LOW_TH+HUM_HYST to return to OK
- LUZ_LOW_TH, 200, light below this is low
- LUZ_HYST, 20, light must reach LUZ_LOW_TH+LUZ_HYST to return to OK
- DEB_N, 4, consecutive disagreeing valid samples needed to flip a channel flag (>=1)
- CLK_HZ, 50000000, iCLK frequency, used for the 1 s prescaler
- WARN_SEC, 30, seconds of continuous DRY before WARNING
- HOLD_CYCLES, 25000000, minimum cycles between message changes (only with MSG_HOLD_EN)

Ports:
- iCLK  in  1  system clock, 50 MHz
- iRST_N  in  1  asynchronous active-low reset
- iHUM_DATA  in  DATA_W  humidity sample
- iHUM_VALID  in  1  one-cycle qualifier for iHUM_DATA
- iLUZ_DATA  in  DATA_W  light sample
- iLUZ_VALID  in  1  one-cycle qualifier for iLUZ_DATA
- iWARN_ACK  in  1  one-cycle pulse, clears WARNING
- oMENSAJE  out  3  message code 0..4 to the LCD block
- oMSG_UPD  out  1  one-cycle pulse when oMENSAJE changes
- oBOMBA  out  1  pump enable

Behaviour:
- Reset (async assert, sync release): oMENSAJE=0, oMSG_UPD=0, oBOMBA=0, hum_low=0, luz_low=0, debounce counters=0, FSM=OK, seconds/prescaler=0, hold counter=0 (expired). Codes 5..7 are never driven.
- Channel classifier, identical per channel and acting only on valid cycles:
  - Candidate state = low if flag=0 and data<LOW_TH (equal to LOW_TH is not low). Candidate state = OK if flag=1 and data>=LOW_TH+HYST. Otherwise the sample agrees with the flag.
  - A disagreeing sample increments the debounce counter. An agreeing sample clears it.
  - On the DEB_N-th consecutive disagreeing sample, the flag toggles at that edge and the counter clears.
  - Non-valid cycles leave the counter unchanged.
  - Both channels are independent. Simultaneous valids on both are legal.
- Dry watchdog FSM:
  - OK: oBOMBA=0. Goes to DRY when hum_low=1; prescaler and seconds counter are cleared on entry.
  - DRY: oBOMBA=1. The prescaler counts to CLK_HZ-1, then wraps and increments seconds (saturating).
    - hum_low=0 -> OK.
    - seconds==WARN_SEC -> WARN.
  - WARN: oBOMBA=0 (tank presumed empty). Only iWARN_ACK leaves, to OK. If hum_low is still 1, the FSM re-enters DRY on the next cycle and counts again from 0.
  - iWARN_ACK outside WARN is ignored. Humidity recovering in WARN does not exit WARN.
- Code selection (combinational next_code): WARN -> 4, else {hum_low,luz_low} -> 0..3.
- Output register: if next_code != oMENSAJE, then oMENSAJE<=next_code and oMSG_UPD=1 for exactly that cycle. Latency is one cycle after the flag or FSM change.
- Reset mid-operation: all state returns to reset values immediately. No pulse is emitted on release.

Optional Feature:
- Macro: MSG_HOLD_EN
- Defined:
  - Non-warning updates require the hold counter to be 0. Every update reloads it to HOLD_CYCLES-1, and it decrements to 0.
  - Pending changes wait, and the latest next_code is applied once the counter expires; intermediate codes are never shown.
  - Entry into code 4 bypasses the hold.
- Not defined: no hold counter. Updates occur on the cycle after next_code changes.

Test Plan (DEB_N=4, CLK_HZ=100, WARN_SEC=3, HOLD_CYCLES=10):
- Reset -> oMENSAJE=0, oBOMBA=0, oMSG_UPD=0. Then 4 valid humidity samples of 299 -> oMENSAJE=2, oBOMBA=1, one oMSG_UPD pulse. Only 3 samples of 299 -> oMENSAJE stays 0.
- Humidity samples 299,299,299,500,299,299,299 -> no flip (counter cleared by 500). With hum_low=1, 4 samples of 319 -> still 2. 4 samples of 320 -> oMENSAJE=0, oBOMBA=0.
- Light 4x150 while humidity low -> oMENSAJE=3. Then light 4x220 -> 2. A sample of exactly 300 for humidity counts as OK.
- Hold humidity low for 300 cycles -> oMENSAJE=4, oBOMBA=0. Humidity back to 500 -> stays 4. iWARN_ACK -> 0. Ack with humidity still low -> 2, pump on again.
- MSG_HOLD_EN defined: light change 4 cycles after a humidity update -> oMENSAJE unchanged until the hold counter expires, then the latest code. Warning during the hold -> 4 on the next cycle.
- Assert iRST_N low while in DRY with seconds=2 -> all outputs 0 immediately. After release, DRY restarts from 0 s.

Source files
------------

// File: rtl/riego_status_encoder.sv
// Sensor-to-LCD message encoder: debounced hysteresis flags, dry-time watchdog, pump enable.
// Latency: oMENSAJE/oMSG_UPD registered one cycle after a flag or watchdog state change.
// No backpressure: samples are taken on their valid cycle. Optional MSG_HOLD_EN rate-limits non-warning updates.
module riego_status_encoder #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned HUM_LOW_TH  = 300,
  parameter int unsigned HUM_HYST    = 20,
  parameter int unsigned LUZ_LOW_TH  = 200,
  parameter int unsigned LUZ_HYST    = 20,
  parameter int unsigned DEB_N       = 4,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned WARN_SEC    = 30,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] iHUM_DATA,
  input  logic              iHUM_VALID,
  input  logic [DATA_W-1:0] iLUZ_DATA,
  input  logic              iLUZ_VALID,
  input  logic              iWARN_ACK,
  output logic [2:0]        oMENSAJE,
  output logic              oMSG_UPD,
  output logic              oBOMBA
);

  // Counter widths; every counter is at least one bit wide even for degenerate parameters.
  localparam int unsigned DEB_W  = (DEB_N > 1) ? $clog2(DEB_N + 1) : 1;
  localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SEC_W  = (WARN_SEC > 0) ? $clog2(WARN_SEC + 1) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(WARN_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

  localparam logic [2:0] CODE_WARN = 3'd4;

  // Parameter sanity: a zero debounce depth, prescaler or hold length has no meaning.
  if (DEB_N < 1 || CLK_HZ < 1 || HOLD_CYCLES < 1) begin : g_param_chk
    $error("riego_status_encoder: DEB_N, CLK_HZ and HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_DRY  = 2'd1,
    ST_WARN = 2'd2
  } state_e;

  // A sample disagrees with the current flag when it argues for the other state.
  // The band between LOW_TH and LOW_TH+HYST always agrees, which gives the hysteresis.
  function automatic logic disagree(input logic              flag,
                                    input logic [DATA_W-1:0] d,
                                    input int unsigned       th,
                                    input int unsigned       hyst);
    int unsigned dv;
    dv = 32'(d);
    if (flag) begin
      return (dv >= th + hyst);
    end
    return (dv < th);
  endfunction

  // ---------------------------------------------------------------------------
  // Channel classifiers
  // ---------------------------------------------------------------------------
  logic             hum_low_q, hum_low_d;
  logic [DEB_W-1:0] hum_cnt_q, hum_cnt_d;
  logic             luz_low_q, luz_low_d;
  logic [DEB_W-1:0] luz_cnt_q, luz_cnt_d;

  // Humidity debounce: count consecutive disagreeing valid samples, flip on the DEB_N-th.
  always_comb begin
    hum_low_d = hum_low_q;
    hum_cnt_d = hum_cnt_q;
    if (iHUM_VALID) begin
      if (disagree(hum_low_q, iHUM_DATA, HUM_LOW_TH, HUM_HYST)) begin
        if (hum_cnt_q == DEB_LAST) begin
          hum_low_d = ~hum_low_q;
          hum_cnt_d = '0;
        end else begin
          hum_cnt_d = hum_cnt_q + DEB_ONE;
        end
      end else begin
        hum_cnt_d = '0;
      end
    end
  end

  // Light debounce: same rule as humidity, fully independent.
  always_comb begin
    luz_low_d = luz_low_q;
    luz_cnt_d = luz_cnt_q;
    if (iLUZ_VALID) begin
      if (disagree(luz_low_q, iLUZ_DATA, LUZ_LOW_TH, LUZ_HYST)) begin
        if (luz_cnt_q == DEB_LAST) begin
          luz_low_d = ~luz_low_q;
          luz_cnt_d = '0;
        end else begin
          luz_cnt_d = luz_cnt_q + DEB_ONE;
        end
      end else begin
        luz_cnt_d = '0;
      end
    end
  end

  // Classifier state registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hum_low_q <= 1'b0;
      hum_cnt_q <= '0;
      luz_low_q <= 1'b0;
      luz_cnt_q <= '0;
    end else begin
      hum_low_q <= hum_low_d;
      hum_cnt_q <= hum_cnt_d;
      luz_low_q <= luz_low_d;
      luz_cnt_q <= luz_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dry-time watchdog
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEC_W-1:0] sec_q, sec_d;

  // Watchdog next state: pump runs while dry; too long dry means the tank is empty.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    case (state_q)
      ST_OK: begin
        if (hum_low_q) begin
          state_d = ST_DRY;
          pre_d   = '0;
          sec_d   = '0;
        end
      end
      ST_DRY: begin
        // Timebase runs every DRY cycle; the seconds count saturates at WARN_SEC.
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (sec_q != SEC_MAX) begin
            sec_d = sec_q + SEC_ONE;
          end
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
        if (!hum_low_q) begin
          state_d = ST_OK;
        end else if (sec_q == SEC_MAX) begin
          state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        // Only the operator leaves WARN; a recovered reading is not trusted here.
        if (iWARN_ACK) begin
          state_d = ST_OK;
        end
      end
      default: begin
        state_d = ST_OK;
      end
    endcase
  end

  // Watchdog registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_OK;
      pre_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
    end
  end

  assign oBOMBA = (state_q == ST_DRY);

  // ---------------------------------------------------------------------------
  // Message selection and output register
  // ---------------------------------------------------------------------------
  logic [2:0] next_code;
  logic [2:0] msg_q, msg_d;
  logic       upd_q, upd_d;

  assign next_code = (state_q == ST_WARN) ? CODE_WARN : {1'b0, hum_low_q, luz_low_q};

`ifdef MSG_HOLD_EN
  localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Rate-limited update: a change waits for the hold to expire, then shows the latest code.
  // Entering WARNING is never delayed.
  always_comb begin
    msg_d  = msg_q;
    upd_d  = 1'b0;
    hold_d = hold_q;
    if ((next_code != msg_q) && ((next_code == CODE_WARN) || (hold_q == '0))) begin
      msg_d  = next_code;
      upd_d  = 1'b1;
      hold_d = HOLD_LAST;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_ONE;
    end
  end

  // Hold counter register; zero means expired.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Immediate update: show any new code on the following cycle with a one-cycle pulse.
  always_comb begin
    msg_d = msg_q;
    upd_d = 1'b0;
    if (next_code != msg_q) begin
      msg_d = next_code;
      upd_d = 1'b1;
    end
  end
`endif

  // Output registers toward the LCD block.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      msg_q <= 3'd0;
      upd_q <= 1'b0;
    end else begin
      msg_q <= msg_d;
      upd_q <= upd_d;
    end
  end

  assign oMENSAJE = msg_q;
  assign oMSG_UPD = upd_q;

endmodule

// File: tb/tb_riego_status_encoder.sv
// Bench for riego_status_encoder: directed scenarios plus randomized segments.
// Every cycle is compared against a behavioural model of the sensor/watchdog rules.
// Build with MSG_HOLD_EN defined to exercise the message hold variant.
module tb_riego_status_encoder;

  localparam int DW   = 10;
  localparam int HTH  = 300;
  localparam int HHY  = 20;
  localparam int LTH  = 200;
  localparam int LHY  = 20;
  localparam int DEB  = 4;
  localparam int CHZ  = 100;
  localparam int WS   = 3;
  localparam int HOLD = 10;

  localparam int M_OK   = 0;
  localparam int M_DRY  = 1;
  localparam int M_WARN = 2;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [DW-1:0] iHUM_DATA = '0;
  logic          iHUM_VALID = 1'b0;
  logic [DW-1:0] iLUZ_DATA = '0;
  logic          iLUZ_VALID = 1'b0;
  logic          iWARN_ACK = 1'b0;
  logic [2:0]    oMENSAJE;
  logic          oMSG_UPD;
  logic          oBOMBA;

  riego_status_encoder #(
    .DATA_W(DW), .HUM_LOW_TH(HTH), .HUM_HYST(HHY), .LUZ_LOW_TH(LTH), .LUZ_HYST(LHY),
    .DEB_N(DEB), .CLK_HZ(CHZ), .WARN_SEC(WS), .HOLD_CYCLES(HOLD)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iHUM_DATA(iHUM_DATA), .iHUM_VALID(iHUM_VALID),
    .iLUZ_DATA(iLUZ_DATA), .iLUZ_VALID(iLUZ_VALID),
    .iWARN_ACK(iWARN_ACK),
    .oMENSAJE(oMENSAJE), .oMSG_UPD(oMSG_UPD), .oBOMBA(oBOMBA)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: sensor flags, watchdog mode, time spent dry, displayed message.
  int m_hum_low, m_luz_low, m_hrun, m_lrun;
  int m_mode, m_age, m_msg, m_upd, m_hold;

  task automatic model_reset();
    m_hum_low = 0; m_luz_low = 0; m_hrun = 0; m_lrun = 0;
    m_mode = M_OK; m_age = 0; m_msg = 0; m_upd = 0; m_hold = 0;
  endtask

  // One channel: a sample "wants low" below TH, or below TH+HYST once already low.
  task automatic chan(input bit v, input int d, input int th, input int hy,
                      input int flag_i, input int run_i, output int flag_o, output int run_o);
    int wants_low;
    flag_o = flag_i;
    run_o  = run_i;
    if (v) begin
      wants_low = (flag_i != 0) ? int'(d < th + hy) : int'(d < th);
      if (wants_low != flag_i) begin
        run_o = run_i + 1;
        if (run_o == DEB) begin
          flag_o = wants_low;
          run_o  = 0;
        end
      end else begin
        run_o = 0;
      end
    end
  endtask

  task automatic model_edge(input bit hv, input int hd, input bit lv, input int ld, input bit ack);
    int code;
    int old_hl;
    code  = (m_mode == M_WARN) ? 4 : (2 * m_hum_low + m_luz_low);
    m_upd = 0;
`ifdef MSG_HOLD_EN
    if (code != m_msg && (code == 4 || m_hold == 0)) begin
      m_msg = code; m_upd = 1; m_hold = HOLD - 1;
    end else if (m_hold > 0) begin
      m_hold--;
    end
`else
    if (code != m_msg) begin
      m_msg = code; m_upd = 1;
    end
`endif
    old_hl = m_hum_low;
    // Warning fires once the dry time reaches WARN_SEC whole seconds.
    case (m_mode)
      M_OK:   if (old_hl != 0) begin m_mode = M_DRY; m_age = 0; end
      M_DRY:  if (old_hl == 0) m_mode = M_OK;
              else if (m_age == WS * CHZ) m_mode = M_WARN;
              else m_age++;
      default: if (ack) m_mode = M_OK;
    endcase
    chan(hv, hd, HTH, HHY, m_hum_low, m_hrun, m_hum_low, m_hrun);
    chan(lv, ld, LTH, LHY, m_luz_low, m_lrun, m_luz_low, m_lrun);
  endtask

  int cyc = 0;

  task automatic step(input bit hv, input int hd, input bit lv, input int ld, input bit ack);
    iHUM_VALID = hv; iHUM_DATA = hd[DW-1:0];
    iLUZ_VALID = lv; iLUZ_DATA = ld[DW-1:0];
    iWARN_ACK  = ack;
    @(posedge iCLK);
    model_edge(hv, hd, lv, ld, ack);
    #1;
    cyc++;
    check("msg", 32'(oMENSAJE), 32'(m_msg));
    check("upd", 32'(oMSG_UPD), 32'(m_upd));
    check("bomba", 32'(oBOMBA), (m_mode == M_DRY) ? 32'd1 : 32'd0);
    iHUM_VALID = 1'b0; iLUZ_VALID = 1'b0; iWARN_ACK = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic hum(input int v, input int n);
    for (int i = 0; i < n; i++) step(1, v, 0, 0, 0);
  endtask

  task automatic luz(input int v, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, v, 0);
  endtask

  // Idle until the message shows code, bounded; reports the number of cycles waited.
  task automatic wait_msg(input int code, input int bound, output int n);
    n = 0;
    while (n < bound && oMENSAJE != 3'(code)) begin
      idle(1);
      n++;
    end
    check("wait_msg", 32'(oMENSAJE), 32'(code));
  endtask

  task automatic do_reset();
    #2;
    iRST_N = 1'b0;
    #1;
    model_reset();
    check("rst_msg", 32'(oMENSAJE), 32'd0);
    check("rst_upd", 32'(oMSG_UPD), 32'd0);
    check("rst_bomba", 32'(oBOMBA), 32'd0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  function automatic int pick(input int th, input int hy);
    case ($urandom_range(0, 5))
      0: return th - 1;
      1: return th;
      2: return th + hy - 1;
      3: return th + hy;
      4: return int'($urandom_range(0, th - 1));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    int n;
    int ht, lt, len;
    model_reset();
    do_reset();

`ifdef MSG_HOLD_EN
    // Light change shortly after a humidity update waits for the hold; warning bypasses it.
    hum(299, 4);
    idle(1);
    check("h_first", 32'(oMENSAJE), 32'd2);
    luz(150, 4);
    idle(4);
    idle(1);
    check("h_held", 32'(oMENSAJE), 32'd2);
    idle(1);
    check("h_release", 32'(oMENSAJE), 32'd3);
    idle(280);
    luz(220, 4);
    idle(6);
    check("h_luz_ok", 32'(oMENSAJE), 32'd2);
    idle(1);
    check("h_pre_warn", 32'(oMENSAJE), 32'd2);
    idle(1);
    check("h_warn_bypass", 32'(oMENSAJE), 32'd4);
`else
    // Debounce depth: three samples are not enough, the fourth flips.
    hum(299, 3);
    idle(2);
    check("deb3_msg", 32'(oMENSAJE), 32'd0);
    hum(299, 1);
    idle(1);
    check("deb4_msg", 32'(oMENSAJE), 32'd2);
    check("deb4_upd", 32'(oMSG_UPD), 32'd1);
    check("deb4_bomba", 32'(oBOMBA), 32'd1);
    idle(1);
    check("upd_single", 32'(oMSG_UPD), 32'd0);
    // Hysteresis band: 319 keeps low, 320 recovers.
    hum(319, 4); idle(1);
    check("hyst_319", 32'(oMENSAJE), 32'd2);
    hum(320, 4); idle(1);
    check("hyst_320", 32'(oMENSAJE), 32'd0);
    check("hyst_bomba", 32'(oBOMBA), 32'd0);
    // An agreeing sample restarts the count.
    hum(299, 3); hum(500, 1); hum(299, 3); idle(1);
    check("deb_clear", 32'(oMENSAJE), 32'd0);
    hum(299, 4); idle(1);
    check("hum_low", 32'(oMENSAJE), 32'd2);
    luz(150, 4); idle(1);
    check("both_low", 32'(oMENSAJE), 32'd3);
    luz(220, 4); idle(1);
    check("luz_back", 32'(oMENSAJE), 32'd2);
    hum(320, 4); hum(300, 4); idle(1);
    check("hum_300_ok", 32'(oMENSAJE), 32'd0);
    // Watchdog: sustained dryness warns and stops the pump until acknowledged.
    hum(299, 4);
    wait_msg(4, 400, n);
    check("warn_bomba", 32'(oBOMBA), 32'd0);
    hum(500, 4); idle(1);
    check("warn_sticky", 32'(oMENSAJE), 32'd4);
    step(0, 0, 0, 0, 1); idle(1);
    check("ack_ok", 32'(oMENSAJE), 32'd0);
    hum(299, 4);
    wait_msg(4, 400, n);
    step(0, 0, 0, 0, 1); idle(1);
    check("ack_dry_msg", 32'(oMENSAJE), 32'd2);
    check("ack_dry_bomba", 32'(oBOMBA), 32'd1);
    // Reset while dry with two seconds elapsed; the dry timer restarts afterwards.
    idle(250);
    do_reset();
    idle(1);
    check("rel_upd", 32'(oMSG_UPD), 32'd0);
    hum(299, 4);
    n = 0;
    while (n < 400 && oMENSAJE != 3'd4) begin
      idle(1);
      n++;
    end
    check("dry_restart_cycles", 32'(n), 32'd303);
`endif

    // Randomized segments around the thresholds, checked cycle by cycle.
    do_reset();
    for (int s = 0; s < 60; s++) begin
      ht  = pick(HTH, HHY);
      lt  = pick(LTH, LHY);
      len = int'($urandom_range(5, 40));
      if ($urandom_range(0, 7) == 0) len = 350;
      for (int k = 0; k < len; k++) begin
        step(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : ht,
             bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : lt,
             ($urandom_range(0, 79) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
